// File: rtl/snes_poll_scheduler.sv
// -----------------------------------------------------------------------------
// snes_poll_scheduler
//
// Drives the shared SNES pad serial bus (LATCH / PULSE) for two pads and
// captures both 12-button words during one poll, so both snapshots come from
// identical bus edges. Polls start periodically (ENABLE + period timer) or on
// demand (START). Requests that cannot start immediately collapse into a
// single pending poll.
//
// Parameters:
//   LATCH_CYC  LATCH high width in clock cycles (>=1)
//   HALF_CYC   PULSE low / high phase width in clock cycles (>=1)
//   POLL_CYC   auto-poll period in clock cycles (>=2)
//
// Ports:
//   CLOCK      system clock
//   RESET_N    asynchronous active-low reset
//   ENABLE     enables periodic auto-polling
//   START      single-cycle on-demand poll request
//   DATA1/2    serial pad data, active-low, already synchronised
//   LATCH      shared pad latch, active-high
//   PULSE      shared pad serial clock, idles high
//   BUSY       high while a poll is in progress
//   VALID      one-cycle strobe when BUTTONS1/2 are updated
//   CHANGED    one-cycle strobe with VALID when either word changed
//   BUTTONS1/2 published button words, 1 = pressed,
//              bit0..11 = B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R
//
// Build option: define SNES_POLL_CHANGE_EN to build the CHANGED detector;
// otherwise CHANGED is tied low.
// -----------------------------------------------------------------------------
module snes_poll_scheduler #(
   parameter int LATCH_CYC = 600,
   parameter int HALF_CYC  = 300,
   parameter int POLL_CYC  = 833333
) (
   input  logic        CLOCK,
   input  logic        RESET_N,
   input  logic        ENABLE,
   input  logic        START,
   input  logic        DATA1,
   input  logic        DATA2,
   output logic        LATCH,
   output logic        PULSE,
   output logic        BUSY,
   output logic        VALID,
   output logic        CHANGED,
   output logic [11:0] BUTTONS1,
   output logic [11:0] BUTTONS2
);

   localparam int MAX_CYC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int TW      = $clog2(POLL_CYC);

   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
   localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_LOW,
      S_HIGH,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  phase_q, phase_d;
   logic [3:0]     bit_q, bit_d;
   logic [15:0]    shift1_q, shift1_d;
   logic [15:0]    shift2_q, shift2_d;
   logic           pend_q, pend_d;
   logic [TW-1:0]  timer_q;
   logic           tick;
   logic           req;

   logic           latch_q, pulse_q, busy_q, valid_q;
   logic [11:0]    buttons1_q, buttons2_q;

   // Free-running period timer; it never waits for the FSM so the poll rate
   // stays locked to the period even when polls are delayed.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         timer_q <= '0;
      end else if (timer_q == POLL_LAST) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_q + TW'(1);
      end
   end

   assign tick = (timer_q == POLL_LAST) & ENABLE;
   assign req  = START | tick;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      shift1_d = shift1_q;
      shift2_d = shift2_q;
      pend_d   = pend_q;

      // Any request arriving during a poll is remembered as one pending poll.
      if (state_q != S_IDLE) begin
         pend_d = pend_q | req;
      end

      case (state_q)
         S_IDLE: begin
            if (pend_q | req) begin
               state_d = S_LATCH;
               phase_d = '0;
               // A pending-launched poll consumes the flag; a fresh request in
               // that same cycle still needs a poll of its own.
               pend_d  = pend_q & req;
            end
         end
         S_LATCH: begin
            if (phase_q == LATCH_LAST) begin
               state_d = S_LOW;
               phase_d = '0;
               bit_d   = '0;
            end else begin
               phase_d = phase_q + CW'(1);
            end
         end
         S_LOW: begin
            if (phase_q == HALF_LAST) begin
               // Sample at the end of the low phase, just before the rising
               // edge that makes the pads shift to the next bit.
               shift1_d[bit_q] = ~DATA1;
               shift2_d[bit_q] = ~DATA2;
               state_d         = S_HIGH;
               phase_d         = '0;
            end else begin
               phase_d = phase_q + CW'(1);
            end
         end
         S_HIGH: begin
            if (phase_q == HALF_LAST) begin
               phase_d = '0;
               if (bit_q == 4'd15) begin
                  state_d = S_DONE;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  state_d = S_LOW;
               end
            end else begin
               phase_d = phase_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up exactly with
   // the state they describe.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         shift1_q   <= '0;
         shift2_q   <= '0;
         pend_q     <= 1'b0;
         latch_q    <= 1'b0;
         pulse_q    <= 1'b1;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         buttons1_q <= '0;
         buttons2_q <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         shift1_q <= shift1_d;
         shift2_q <= shift2_d;
         pend_q   <= pend_d;
         latch_q  <= (state_d == S_LATCH);
         pulse_q  <= (state_d != S_LOW);
         busy_q   <= (state_d != S_IDLE);
         valid_q  <= (state_d == S_DONE);
         // Only a completed poll publishes; bits 12..15 are discarded.
         if (state_d == S_DONE) begin
            buttons1_q <= shift1_q[11:0];
            buttons2_q <= shift2_q[11:0];
         end
      end
   end

`ifdef SNES_POLL_CHANGE_EN
   logic changed_q;

   // The published words are the "previous" words at the moment of DONE.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= (state_d == S_DONE) &&
                      ((shift1_q[11:0] != buttons1_q) ||
                       (shift2_q[11:0] != buttons2_q));
      end
   end

   assign CHANGED = changed_q;
`else
   assign CHANGED = 1'b0;
`endif

   assign LATCH    = latch_q;
   assign PULSE    = pulse_q;
   assign BUSY     = busy_q;
   assign VALID    = valid_q;
   assign BUTTONS1 = buttons1_q;
   assign BUTTONS2 = buttons2_q;

endmodule

// File: tb/tb_snes_poll_scheduler.sv
module tb_snes_poll_scheduler;

   localparam int L      = 6;
   localparam int H      = 3;
   localparam int POLL_A = 200;
   localparam int POLL_B = 50;
   localparam int P      = L + 32 * H + 1;   // request cycle to VALID
   localparam int NONE   = -1000000;
`ifdef SNES_POLL_CHANGE_EN
   localparam logic CHG_EN = 1'b1;
`else
   localparam logic CHG_EN = 1'b0;
`endif

   logic CLOCK = 1'b0;
   logic RESET_N, ENABLE, START, ENABLE_b;
   logic DATA1, DATA2;
   logic LATCH, PULSE, BUSY, VALID, CHANGED;
   logic [11:0] BUTTONS1, BUTTONS2;
   logic LATCH_b, PULSE_b, BUSY_b, VALID_b, CHANGED_b;
   logic [11:0] BUTTONS1_b, BUTTONS2_b;
   logic zero_b = 1'b0;
   logic one_b  = 1'b1;

   always #5 CLOCK = ~CLOCK;

   snes_poll_scheduler #(.LATCH_CYC(L), .HALF_CYC(H), .POLL_CYC(POLL_A)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .START(START),
      .DATA1(DATA1), .DATA2(DATA2), .LATCH(LATCH), .PULSE(PULSE),
      .BUSY(BUSY), .VALID(VALID), .CHANGED(CHANGED),
      .BUTTONS1(BUTTONS1), .BUTTONS2(BUTTONS2));

   // Second instance with a period shorter than a poll: back-to-back polls.
   snes_poll_scheduler #(.LATCH_CYC(L), .HALF_CYC(H), .POLL_CYC(POLL_B)) dut_b (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE_b), .START(zero_b),
      .DATA1(one_b), .DATA2(one_b), .LATCH(LATCH_b), .PULSE(PULSE_b),
      .BUSY(BUSY_b), .VALID(VALID_b), .CHANGED(CHANGED_b),
      .BUTTONS1(BUTTONS1_b), .BUTTONS2(BUTTONS2_b));

   // Pad model: loads while LATCH is high, shifts on each PULSE rise.
   logic [11:0] word1 = '0, word2 = '0;
   logic [3:0]  top1 = '0, top2 = '0;
   logic [15:0] sr1 = '0, sr2 = '0;
   logic        pulse_prev = 1'b1;
   always @(posedge CLOCK) begin
      pulse_prev <= PULSE;
      if (LATCH) begin
         sr1 <= {top1, word1};
         sr2 <= {top2, word2};
      end else if (PULSE && !pulse_prev) begin
         sr1 <= {1'b0, sr1[15:1]};
         sr2 <= {1'b0, sr2[15:1]};
      end
   end
   assign DATA1 = ~sr1[0];
   assign DATA2 = ~sr2[0];

   // Reference model state: poll start cycle, pending flag, published words.
   int          n_cmp = 0, n_err = 0;
   int          c, t_start;
   bit          pend;
   logic [11:0] snap1, snap2, exp_b1, exp_b2;
   logic        e_latch, e_pulse, e_busy, e_valid, e_changed;
   int          n_valid, n_valid_b, b_last, a_last, last_valid_c;
   logic        last_changed;
   bit          per_mode;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   task automatic model_reset();
      c = 0; t_start = NONE; pend = 1'b0;
      exp_b1 = '0; exp_b2 = '0; snap1 = '0; snap2 = '0;
      b_last = -1; a_last = -1;
   endtask

   task automatic step();
      int d;
      bit busy, req;
      @(posedge CLOCK);
      d    = c - t_start;
      busy = (d >= 1) && (d <= P);
      req  = (START === 1'b1) || ((ENABLE === 1'b1) && (c % POLL_A == POLL_A - 1));
      if (!busy) begin
         if (pend) begin
            t_start = c;
            pend    = req;
         end else if (req) begin
            t_start = c;
         end
      end else if (req) begin
         pend = 1'b1;
      end
      c++;
      #1;
      d = c - t_start;
      if (d == 1) begin
         snap1 = word1;
         snap2 = word2;
      end
      e_latch   = (d >= 1) && (d <= L);
      e_pulse   = !((d > L) && (d <= L + 32 * H) && (((d - L - 1) / H) % 2 == 0));
      e_busy    = (d >= 1) && (d <= P);
      e_valid   = (d == P);
      e_changed = 1'b0;
      if (e_valid) begin
         e_changed = CHG_EN && ((snap1 != exp_b1) || (snap2 != exp_b2));
         exp_b1    = snap1;
         exp_b2    = snap2;
      end
      chk("ctrl", {27'd0, LATCH, PULSE, BUSY, VALID, CHANGED},
          {27'd0, e_latch, e_pulse, e_busy, e_valid, e_changed});
      chk("buttons", {8'd0, BUTTONS1, BUTTONS2}, {8'd0, exp_b1, exp_b2});
      if (VALID === 1'b1) begin
         n_valid++;
         last_valid_c = c;
         last_changed = CHANGED;
         if (per_mode && a_last >= 0) chk("a_period", c - a_last, POLL_A);
         a_last = c;
      end
      if (VALID_b === 1'b1) begin
         if (b_last >= 0) chk("b_gap", c - b_last, P + 1);
         b_last = c;
         n_valid_b++;
      end
   endtask

   task automatic run_until_idle();
      int n;
      n = 0;
      while ((((c - t_start) >= 1) && ((c - t_start) <= P)) || pend) begin
         step();
         n++;
         if (n > 1000) begin
            n_cmp++;
            n_err++;
            $error("FAIL idle_timeout cyc=%0d observed=busy required=idle", c);
            break;
         end
      end
   endtask

   task automatic step_to(input int dd);
      int n;
      n = 0;
      while ((c - t_start) != dd) begin
         step();
         n++;
         if (n > 300) begin
            n_cmp++;
            n_err++;
            $error("FAIL step_timeout cyc=%0d observed=%0d required=%0d", c, c - t_start, dd);
            break;
         end
      end
   endtask

   task automatic poll_once();
      START = 1'b1;
      step();
      START = 1'b0;
      run_until_idle();
      step();
   endtask

   initial begin
      int t_req;
      RESET_N = 1'b0; ENABLE = 1'b0; START = 1'b0; ENABLE_b = 1'b0;
      per_mode = 1'b0; n_valid = 0; n_valid_b = 0; last_changed = 1'b0;
      last_valid_c = 0;
      repeat (3) @(posedge CLOCK);
      #1 RESET_N = 1'b1;
      model_reset();
      chk("reset_ctrl", {27'd0, LATCH, PULSE, BUSY, VALID, CHANGED}, 32'h08);
      chk("reset_buttons", {8'd0, BUTTONS1, BUTTONS2}, 32'd0);
      repeat (5) step();

      // Directed poll: pad1 bits 0 and 8, pad2 bit 3.
      word1 = 12'h101; word2 = 12'h008; top1 = 4'h0; top2 = 4'h0;
      n_valid = 0;
      START = 1'b1;
      t_req = c;
      step();
      START = 1'b0;
      run_until_idle();
      chk("t1_valid_cycle", last_valid_c - t_req, P);
      chk("t1_valid_count", n_valid, 1);
      chk("t1_buttons1", BUTTONS1, 12'h101);
      chk("t1_buttons2", BUTTONS2, 12'h008);
      chk("t1_busy_fall", BUSY, 1'b0);

      // Random words, random discarded upper bits.
      for (int i = 0; i < 3; i++) begin
         word1 = 12'($urandom); word2 = 12'($urandom);
         top1 = 4'($urandom); top2 = 4'($urandom);
         poll_once();
      end

      // Three STARTs during one poll collapse into a single extra poll.
      n_valid = 0;
      START = 1'b1; step(); START = 1'b0;
      step_to(10);      START = 1'b1; step(); START = 1'b0;
      step_to(40);      START = 1'b1; step(); START = 1'b0;
      step_to(80 + $urandom_range(0, 15)); START = 1'b1; step(); START = 1'b0;
      t_req = last_valid_c;
      run_until_idle();
      repeat (150) step();
      chk("start3_valid_count", n_valid, 2);

      // CHANGED behaviour: new word, same word, then pad2 changes.
      word1 = ~exp_b1 | 12'h001; word2 = 12'($urandom);
      poll_once();
      chk("chg_first", last_changed, CHG_EN);
      poll_once();
      chk("chg_same", last_changed, 1'b0);
      word2 = word2 ^ 12'h040;
      poll_once();
      chk("chg_pad2", last_changed, CHG_EN);

      // Periodic polling on both instances.
      n_valid = 0; n_valid_b = 0; per_mode = 1'b1; a_last = -1; b_last = -1;
      ENABLE = 1'b1; ENABLE_b = 1'b1;
      repeat (700) step();
      ENABLE = 1'b0; ENABLE_b = 1'b0; per_mode = 1'b0;
      run_until_idle();
      repeat (250) step();
      chk("a_period_count", n_valid >= 3, 1'b1);
      chk("b_back_to_back_count", n_valid_b >= 5, 1'b1);

      // Reset during the LOW phase of bit 7.
      word1 = 12'($urandom) | 12'h001;
      START = 1'b1; step(); START = 1'b0;
      step_to(L + 1 + 14 * H + 1);
      RESET_N = 1'b0;
      #1;
      chk("rst_latch", LATCH, 1'b0);
      chk("rst_pulse", PULSE, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_valid", VALID, 1'b0);
      chk("rst_buttons", {8'd0, BUTTONS1, BUTTONS2}, 32'd0);
      repeat (2) @(posedge CLOCK);
      #1 RESET_N = 1'b1;
      model_reset();
      n_valid = 0;
      repeat (300) step();
      chk("post_reset_no_valid", n_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
